// File: rtl/md_hilo_unit_pkg.sv
// Shared constants for the multiply/divide unit: md_op encodings and the
// HI/LO forwarding select codes used by the hazard unit.
package md_hilo_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_M    = 2'd1;
    localparam logic [1:0] FWD_W    = 2'd2;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_hilo_unit_arith.sv
// Combinational HI/LO result generator for the latched multiply/divide operands.
// commit_en is low for a divide by zero so HI/LO keep their old values.
module md_arith
    import md_hilo_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_tmp,
    output logic [31:0] lo_tmp,
    output logic        commit_en
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               signed_div;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        prod_s     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u     = {32'd0, a} * {32'd0, b};
        signed_div = (op == MD_DIV);
        abs_a      = (signed_div && a[31]) ? -a : a;
        abs_b      = (signed_div && b[31]) ? -b : b;
        quo_u      = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
        rem_u      = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
        hi_tmp     = 32'd0;
        lo_tmp     = 32'd0;
        commit_en  = 1'b0;
        case (op)
            MD_MULT: begin
                hi_tmp    = prod_s[63:32];
                lo_tmp    = prod_s[31:0];
                commit_en = 1'b1;
            end
            MD_MULTU: begin
                hi_tmp    = prod_u[63:32];
                lo_tmp    = prod_u[31:0];
                commit_en = 1'b1;
            end
            MD_DIV: begin
                lo_tmp    = (a[31] ^ b[31]) ? -quo_u : quo_u;
                hi_tmp    = a[31] ? -rem_u : rem_u;
                commit_en = (b != 32'd0);
            end
            MD_DIVU: begin
                lo_tmp    = quo_u;
                hi_tmp    = rem_u;
                commit_en = (b != 32'd0);
            end
            default: begin
                hi_tmp    = 32'd0;
                lo_tmp    = 32'd0;
                commit_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_hilo_unit.sv
// Multiply/divide unit owning architectural HI/LO, with a busy handshake
// that lets the hazard unit stall dependent instructions in D.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no operation in flight; accepts mult/div and MTHI/MTLO
// BUSY    | mult/div in flight; counter runs N..1, commit at 1
module md_hilo_unit
    import md_hilo_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_hazard,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [4:0] CNT_MULT = 5'(MULT_CYCLES);
    localparam logic [4:0] CNT_DIV  = 5'(DIV_CYCLES);

    logic [0:0]  state;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    hilo_t       shadow;
    logic        commit_en;

    md_arith u_arith (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .hi_tmp    (shadow.hi),
        .lo_tmp    (shadow.lo),
        .commit_en (commit_en)
    );

    assign busy      = (state == ST_BUSY);
    assign md_hazard = busy | (start & is_md_op(md_op));

    // Requests arriving while BUSY are dropped, so HI/LO only move at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                if (is_md_op(md_op)) begin
                    state <= ST_BUSY;
                    cnt   <= is_mul_op(md_op) ? CNT_MULT : CNT_DIV;
                    op_q  <= md_op;
                    a_q   <= A;
                    b_q   <= B;
                end else if (md_op == MD_MTHI) begin
                    hi <= A;
                end else if (md_op == MD_MTLO) begin
                    lo <= A;
                end
            end
        end else begin
            if (cnt == 5'd1) begin
                state <= ST_IDLE;
                cnt   <= 5'd0;
                if (commit_en) begin
                    hi <= shadow.hi;
                    lo <= shadow.lo;
                end
            end else begin
                cnt <= cnt - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Scoreboard bench for md_hilo_unit: stimulus pushes expected commits,
// a negedge monitor pops and compares whenever busy falls.
module tb_md_hilo_unit;
    import md_hilo_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_hazard;
    logic [31:0] hi;
    logic [31:0] lo;

    md_hilo_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .md_hazard (md_hazard),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          run = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: a busy falling edge is the DUT presenting a result.
    always @(negedge clk) begin
        if (reset) begin
            run       = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                run++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL commit_unexpected actual=hi 0x%08h lo 0x%08h required=no commit", hi, lo);
                end else begin
                    mon_e = sb.pop_front();
                    check32("commit_hi", hi, mon_e.hi);
                    check32("commit_lo", lo, mon_e.lo);
                    check32("busy_len", 32'(run), 32'(mon_e.n));
                end
                run = 0;
            end
            prev_busy = busy;
        end
    end

    // Drive a mult/div at a negedge; returns at the negedge of busy cycle 1.
    task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input int n,
                            input bit push);
        exp_t e;
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        #1;
        check32("hazard_start", {31'd0, md_hazard}, 32'd1);
        e.hi = ehi;
        e.lo = elo;
        e.n  = n;
        if (push) sb.push_back(e);
        pend_hi = ehi;
        pend_lo = elo;
        @(negedge clk);
        start = 1'b0;
        check32("busy_cycle1", {31'd0, busy}, 32'd1);
        check32("hi_hold", hi, exp_hi);
        check32("lo_hold", lo, exp_lo);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=busy required=idle within 50 cycles");
        end
        exp_hi = pend_hi;
        exp_lo = pend_lo;
    endtask

    task automatic issue_mt(input logic [2:0] op, input logic [31:0] a);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = 32'd0;
        #1;
        check32("hazard_mt", {31'd0, md_hazard}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        if (op == MD_MTHI) exp_hi = a;
        if (op == MD_MTLO) exp_lo = a;
        check32("mt_hi", hi, exp_hi);
        check32("mt_lo", lo, exp_lo);
        check32("mt_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_hazard", {31'd0, md_hazard}, 32'd0);

        issue_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b1);
        wait_idle();
        issue_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, 1'b1);
        wait_idle();
        issue_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1);
        wait_idle();
        issue_op(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b1);
        wait_idle();

        issue_mt(MD_MTHI, 32'h1234_5678);
        issue_op(MD_DIVU, 32'd5, 32'd0, 32'h1234_5678, 32'd3, 10, 1'b1);
        wait_idle();
        issue_mt(MD_MTLO, 32'h0000_00AB);

        issue_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b1);
        wait_idle();

        // Unused op code with start must do nothing.
        start = 1'b1;
        md_op = 3'd7;
        A     = 32'hFFFF_FFFF;
        #1;
        check32("inv_hazard", {31'd0, md_hazard}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check32("inv_busy", {31'd0, busy}, 32'd0);
        check32("inv_hi", hi, exp_hi);
        check32("inv_lo", lo, exp_lo);

        // Requests during busy are ignored.
        issue_op(MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b1);
        start = 1'b1;
        md_op = MD_MTHI;
        A     = 32'h0000_DEAD;
        @(negedge clk);
        check32("busy_hazard", {31'd0, md_hazard}, 32'd1);
        md_op = MD_DIV;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check32("busy_hi_hold", hi, 32'd0);
        wait_idle();
        repeat (3) @(negedge clk);
        check32("ignored_div_busy", {31'd0, busy}, 32'd0);
        check32("ignored_hi", hi, 32'd0);
        check32("ignored_lo", lo, 32'd12);

        // Reset mid-operation discards the pending result.
        issue_op(MD_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        repeat (10) @(negedge clk);
        check32("post_abort_busy", {31'd0, busy}, 32'd0);
        check32("post_abort_hi", hi, 32'd0);
        check32("post_abort_lo", lo, 32'd0);
        check32("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
